// File: rtl/nanorv32_pkg.sv
// -----------------------------------------------------------------------------
// nanorv32_pkg
// Shared definitions for the nanorv32 instruction prefetch path.
//   NRV32_ADDR_MSB / NRV32_DATA_MSB : MSB index of code address / instruction word
//   NRV32_RESET_PC                  : default first fetch address after reset
//   pf_state_t                      : prefetch FSM state encoding
// -----------------------------------------------------------------------------
package nanorv32_pkg;

    localparam int          NRV32_ADDR_MSB = 31;
    localparam int          NRV32_DATA_MSB = 31;
    localparam logic [31:0] NRV32_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request on the bus (or about to be issued)
        S_STALL = 2'd1,   // no room in the FIFO, bus idle
        S_DROP  = 2'd2    // stale request in flight, its response is discarded
    } pf_state_t;

endpackage

// File: rtl/nanorv32_fetch_fifo.sv
// -----------------------------------------------------------------------------
// nanorv32_fetch_fifo
// DEPTH-entry synchronous FIFO of {pc, instr} pairs. Implemented as a shift
// register whose entry 0 is always the head, so the head outputs come straight
// from flops.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_push         : write {i_pc, i_instr} at the tail
//   i_pop          : drop the head entry
//   i_clear        : empty the FIFO (overrides push and pop)
//   o_count        : number of valid entries
//   o_head_valid   : FIFO not empty
//   o_head_pc      : PC of head entry
//   o_head_instr   : instruction of head entry
// -----------------------------------------------------------------------------
module nanorv32_fetch_fifo #(
    parameter  int DEPTH  = 2,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    input  logic              i_pop,
    input  logic              i_clear,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_head_valid,
    output logic [ADDR_W-1:0] o_head_pc,
    output logic [DATA_W-1:0] o_head_instr
);

    logic [ADDR_W-1:0] r_pc      [DEPTH];
    logic [DATA_W-1:0] r_instr   [DEPTH];
    logic [ADDR_W-1:0] w_pc_next [DEPTH];
    logic [DATA_W-1:0] w_instr_next [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push & ~i_clear;
    assign w_pop  = i_pop  & ~i_clear;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_load;
            logic w_shift;
            // The new word lands in the first free slot, which moves down by
            // one when the head is popped in the same cycle.
            assign w_load  = w_push & (w_pop ? (r_count == CNT_W'(gi + 1))
                                             : (r_count == CNT_W'(gi)));
            assign w_shift = w_pop & ~w_load;
            if (gi < DEPTH - 1) begin : g_mid
                assign w_pc_next[gi]    = w_load ? i_pc    : (w_shift ? r_pc[gi+1]    : r_pc[gi]);
                assign w_instr_next[gi] = w_load ? i_instr : (w_shift ? r_instr[gi+1] : r_instr[gi]);
            end else begin : g_last
                assign w_pc_next[gi]    = w_load ? i_pc    : r_pc[gi];
                assign w_instr_next[gi] = w_load ? i_instr : r_instr[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else begin
            if (i_clear) r_count <= '0;
            else         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= w_pc_next[i];
                r_instr[i] <= w_instr_next[i];
            end
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != '0);
    assign o_head_pc    = r_pc[0];
    assign o_head_instr = r_instr[0];

endmodule

// File: rtl/nanorv32_prefetch.sv
// -----------------------------------------------------------------------------
// nanorv32_prefetch
// Instruction prefetch unit: code-memory bus master feeding the decode stage.
// Issues sequential word fetches, buffers {pc, instr} in a small FIFO and
// handles branch redirects, including disposal of an in-flight request.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cpu_codemem_addr/_valid      : fetch request (registered)
//   codemem_cpu_rdata/_ready     : fetch response, completes when ready=1
//   branch_taken/branch_target   : one-cycle redirect from the core
//   pf_instr/pf_pc/pf_valid      : FIFO head toward the core
//   pf_ready                     : core consumes head when pf_valid&pf_ready
// -----------------------------------------------------------------------------
module nanorv32_prefetch
    import nanorv32_pkg::*;
#(
    parameter  int              ADDR_W   = NRV32_ADDR_MSB + 1,
    parameter  int              DATA_W   = NRV32_DATA_MSB + 1,
    parameter  int              DEPTH    = 2,
    parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NRV32_RESET_PC),
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] cpu_codemem_addr,
    output logic              cpu_codemem_valid,
    input  logic [DATA_W-1:0] codemem_cpu_rdata,
    input  logic              codemem_cpu_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] pf_instr,
    output logic [ADDR_W-1:0] pf_pc,
    output logic              pf_valid,
    input  logic              pf_ready
);

    pf_state_t         r_state;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    // Address of the current/next request; in S_DROP it holds the redirect
    // target so the last branch seen while draining wins.
    logic [ADDR_W-1:0] r_fetch_pc;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_space;

    assign w_target = branch_target & ~ADDR_W'(3);
    assign w_pc_inc = r_fetch_pc + ADDR_W'(4);
    assign w_hs     = r_valid & codemem_cpu_ready;
    assign w_push   = w_hs & (r_state == S_FETCH) & ~branch_taken;
    assign w_pop    = pf_valid & pf_ready & ~branch_taken;

    // Only one request is ever outstanding, and a new one is issued only after
    // the previous completes, so room for it is judged on next-cycle occupancy.
    assign w_count_next = branch_taken ? '0
                        : w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space      = (w_count_next < CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_valid    <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_valid) begin
                        // First request after reset.
                        r_valid    <= 1'b1;
                        r_addr     <= branch_taken ? w_target : r_fetch_pc;
                        if (branch_taken) r_fetch_pc <= w_target;
                    end else if (codemem_cpu_ready) begin
                        if (branch_taken) begin
                            r_addr     <= w_target;
                            r_fetch_pc <= w_target;
                        end else begin
                            r_fetch_pc <= w_pc_inc;
                            if (w_space) begin
                                r_addr <= w_pc_inc;
                            end else begin
                                r_valid <= 1'b0;
                                r_state <= S_STALL;
                            end
                        end
                    end else if (branch_taken) begin
                        // Request must stay on the bus until it completes.
                        r_fetch_pc <= w_target;
                        r_state    <= S_DROP;
                    end
                end
                S_STALL: begin
                    if (branch_taken) begin
                        r_valid    <= 1'b1;
                        r_addr     <= w_target;
                        r_fetch_pc <= w_target;
                        r_state    <= S_FETCH;
                    end else if (w_space) begin
                        r_valid <= 1'b1;
                        r_addr  <= r_fetch_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (branch_taken) r_fetch_pc <= w_target;
                    if (codemem_cpu_ready) begin
                        // FIFO was cleared on entry, so there is always room.
                        r_addr  <= branch_taken ? w_target : r_fetch_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    nanorv32_fetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pc         (r_addr),
        .i_instr      (codemem_cpu_rdata),
        .i_pop        (w_pop),
        .i_clear      (branch_taken),
        .o_count      (w_count),
        .o_head_valid (pf_valid),
        .o_head_pc    (pf_pc),
        .o_head_instr (pf_instr)
    );

    assign cpu_codemem_addr  = r_addr;
    assign cpu_codemem_valid = r_valid;

endmodule

// File: tb/tb_nanorv32_prefetch.sv
// -----------------------------------------------------------------------------
// tb_nanorv32_prefetch
// Directed bench for nanorv32_prefetch: a table of per-cycle vectors plus
// hand-written sequences for redirects during a stalled request, address wrap
// and asynchronous reset mid-request.
// -----------------------------------------------------------------------------
module tb_nanorv32_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_codemem_addr;
    logic        cpu_codemem_valid;
    logic [31:0] codemem_cpu_rdata;
    logic        codemem_cpu_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pf_instr;
    logic [31:0] pf_pc;
    logic        pf_valid;
    logic        pf_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Code memory content: a scrambled function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign codemem_cpu_rdata = mem_word(cpu_codemem_addr);

    nanorv32_prefetch dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_codemem_addr  (cpu_codemem_addr),
        .cpu_codemem_valid (cpu_codemem_valid),
        .codemem_cpu_rdata (codemem_cpu_rdata),
        .codemem_cpu_ready (codemem_cpu_ready),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pf_instr          (pf_instr),
        .pf_pc             (pf_pc),
        .pf_valid          (pf_valid),
        .pf_ready          (pf_ready)
    );

    typedef struct {
        logic        rst;
        logic        mrdy;
        logic        prdy;
        logic        br;
        logic [31:0] tgt;
        logic        ev;    // expected cpu_codemem_valid
        logic [31:0] ea;    // expected cpu_codemem_addr (checked when ev or rst)
        logic        epv;   // expected pf_valid
        logic [31:0] epc;   // expected pf_pc (checked when epv)
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic m, input logic p, input logic b,
                       input logic [31:0] t, input logic ev, input logic [31:0] ea,
                       input logic epv, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.mrdy = m; v.prdy = p; v.br = b; v.tgt = t;
        v.ev = ev; v.ea = ea; v.epv = epv; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic m, input logic p, input logic b, input logic [31:0] t);
        codemem_cpu_ready = m;
        pf_ready          = p;
        branch_taken      = b;
        branch_target     = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [31:0] ea,
                           input logic chk_a, input logic epv, input logic [31:0] epc);
        chk({name, ".valid"}, {31'd0, cpu_codemem_valid}, {31'd0, ev});
        if (ev || chk_a) chk({name, ".addr"}, cpu_codemem_addr, ea);
        chk({name, ".pf_valid"}, {31'd0, pf_valid}, {31'd0, epv});
        if (epv) begin
            chk({name, ".pf_pc"}, pf_pc, epc);
            chk({name, ".pf_instr"}, pf_instr, mem_word(epc));
        end
    endtask

    initial begin
        rst = 1'b1;
        codemem_cpu_ready = 1'b0;
        pf_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;

        // Streaming, zero-wait memory, core always ready.
        add(1,0,0,0,0,        0,0,      0,0);
        add(0,1,1,0,0,        1,0,      0,0);
        add(0,1,1,0,0,        1,4,      1,0);
        add(0,1,1,0,0,        1,8,      1,4);
        add(0,1,1,0,0,        1,12,     1,8);
        // Core stalled: exactly two handshakes, then fetch resumes at 8.
        add(1,0,0,0,0,        0,0,      0,0);
        add(0,1,0,0,0,        1,0,      0,0);
        add(0,1,0,0,0,        1,4,      1,0);
        add(0,1,0,0,0,        0,0,      1,0);
        add(0,1,0,0,0,        0,0,      1,0);
        add(0,1,1,0,0,        1,8,      1,4);
        add(0,1,1,0,0,        1,12,     1,8);
        // Branch coincident with memory ready and pop.
        add(0,1,1,1,32'h200,  1,32'h200,0,0);
        add(0,1,1,0,0,        1,32'h204,1,32'h200);
        add(0,1,1,0,0,        1,32'h208,1,32'h204);
        // Branch while request 0x10 waits three cycles; its data is dropped.
        add(1,0,0,0,0,        0,0,      0,0);
        add(0,1,1,0,0,        1,0,      0,0);
        add(0,1,1,0,0,        1,4,      1,0);
        add(0,1,1,0,0,        1,8,      1,4);
        add(0,1,1,0,0,        1,32'hC,  1,8);
        add(0,1,1,0,0,        1,32'h10, 1,32'hC);
        add(0,0,1,1,32'h103,  1,32'h10, 0,0);
        add(0,0,1,0,0,        1,32'h10, 0,0);
        add(0,0,1,0,0,        1,32'h10, 0,0);
        add(0,1,1,0,0,        1,32'h100,0,0);
        add(0,1,1,0,0,        1,32'h104,1,32'h100);

        @(posedge clk);
        @(posedge clk);
        #1;
        // Outputs while held in reset.
        chk("reset.valid",    {31'd0, cpu_codemem_valid}, 32'd0);
        chk("reset.addr",     cpu_codemem_addr, 32'h0);
        chk("reset.pf_valid", {31'd0, pf_valid}, 32'd0);
        chk("reset.pf_pc",    pf_pc, 32'h0);
        chk("reset.pf_instr", pf_instr, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            step(vecs[i].mrdy, vecs[i].prdy, vecs[i].br, vecs[i].tgt);
            $display("vec %0d rst=%0b mrdy=%0b prdy=%0b br=%0b -> valid=%0b addr=%h pf_valid=%0b pf_pc=%h",
                     i, vecs[i].rst, vecs[i].mrdy, vecs[i].prdy, vecs[i].br,
                     cpu_codemem_valid, cpu_codemem_addr, pf_valid, pf_pc);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].rst,
                    vecs[i].epv, vecs[i].epc);
        end

        // Two redirects while draining: only the last target is fetched.
        rst = 1'b1;
        step(0, 1, 0, 0);
        rst = 1'b0;
        step(1, 1, 0, 0);            chk_out("drop.issue",  1, 32'h0,   0, 0, 0);
        step(0, 1, 1, 32'h300);      chk_out("drop.br1",    1, 32'h0,   0, 0, 0);
        step(0, 1, 1, 32'h400);      chk_out("drop.br2",    1, 32'h0,   0, 0, 0);
        step(1, 1, 0, 0);            chk_out("drop.redir",  1, 32'h400, 0, 0, 0);
        step(1, 1, 0, 0);            chk_out("drop.first",  1, 32'h404, 0, 1, 32'h400);
        $display("seq drop: addr=%h pf_pc=%h", cpu_codemem_addr, pf_pc);

        // Address wrap; target low bits are ignored.
        step(1, 1, 1, 32'hFFFF_FFFF); chk_out("wrap.redir", 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 1, 0, 0);             chk_out("wrap.top",   1, 32'h0, 0, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);             chk_out("wrap.zero",  1, 32'h4, 0, 1, 32'h0);
        $display("seq wrap: addr=%h pf_pc=%h", cpu_codemem_addr, pf_pc);

        // Asynchronous reset in the middle of a waiting request.
        step(0, 0, 0, 0);             chk_out("arst.pend",  1, 32'h4, 0, 1, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid",    {31'd0, cpu_codemem_valid}, 32'd0);
        chk("arst.addr",     cpu_codemem_addr, 32'h0);
        chk("arst.pf_valid", {31'd0, pf_valid}, 32'd0);
        chk("arst.pf_instr", pf_instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0, 0);             chk_out("arst.restart", 1, 32'h0, 0, 0, 0);
        step(1, 1, 0, 0);             chk_out("arst.next",    1, 32'h4, 0, 1, 32'h0);
        $display("seq arst: addr=%h pf_pc=%h", cpu_codemem_addr, pf_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanorv32_prefetch.md
Name: nanorv32_prefetch

Overview:
Instruction prefetch unit sitting directly upstream of the nanorv32 decode/execute core, between the code memory port and the core. It is the code-memory bus master: it issues sequential word fetches, buffers returned instructions with their PCs in a small FIFO, and presents them to the core through a valid/ready interface. A taken branch from the core flushes the FIFO and redirects fetch, including correct disposal of an in-flight request.

Parameters:
ADDR_W, 32, address width (NRV32_ADDR_MSB+1)
DATA_W, 32, instruction word width (NRV32_DATA_MSB+1)
DEPTH, 2, FIFO entries; power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cpu_codemem_addr  out  ADDR_W  fetch address, word aligned
cpu_codemem_valid  out  1  fetch request
codemem_cpu_rdata  in  DATA_W  fetched word, valid in cycle ready=1
codemem_cpu_ready  in  1  memory completes the request this cycle
branch_taken  in  1  core redirect strobe, one cycle
branch_target  in  ADDR_W  redirect address; bits [1:0] ignored (treated as 0)
pf_instr  out  DATA_W  instruction at FIFO head
pf_pc  out  ADDR_W  PC of pf_instr
pf_valid  out  1  FIFO head valid
pf_ready  in  1  core consumes head when pf_valid&pf_ready

Behaviour:
- Reset is asynchronous, active-high. On reset: cpu_codemem_valid=0, cpu_codemem_addr=RESET_PC, FIFO empty (pf_valid=0), pf_instr=0, pf_pc=0, state=S_FETCH, fetch_pc=RESET_PC. Reset asserted mid-request drops the request immediately; no response is consumed.
- Memory handshake: transfer when valid&ready. Once valid=1, addr is held stable and valid stays high until ready (even across a flush). rdata is sampled in the ready cycle. At most one request outstanding.
- All codemem outputs are registered. First request: valid=1, addr=RESET_PC in the first clk edge after rst deasserts.
- FIFO: push on accepted response (not discarded), pop on pf_valid&pf_ready. Push and pop in the same cycle are allowed at any count, including full. pf_* driven from registered head entry; a pushed word appears on pf_* the cycle after the handshake (1-cycle fetch-to-decode latency with zero-wait memory).
- Issue rule: next-cycle valid=1 only if next-cycle count + outstanding < DEPTH; otherwise S_STALL. With zero-wait memory and pf_ready=1, sustained throughput is 1 instruction/cycle.
- fetch_pc increments by 4 per accepted request and wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- States:
  S_FETCH: valid=1. ready&~flush -> push, advance pc; stay or go to S_STALL if no space.
  S_STALL: valid=0. Space available -> S_FETCH, addr=fetch_pc.
  S_DROP: valid=1 with stale addr; response on ready is discarded -> S_FETCH at the redirect address.
- Flush (branch_taken=1): FIFO cleared next cycle (pf_valid=0); pop in the same cycle is ignored; fetch_pc=target&~3.
  In S_FETCH with ready=1 same cycle: response discarded; next cycle valid=1, addr=target.
  In S_FETCH with ready=0: -> S_DROP; target latched.
  In S_STALL: next cycle valid=1, addr=target.
  In S_DROP: latched target overwritten by the new target (last redirect wins).
- No push ever occurs in the flush cycle or in S_DROP.

Decomposition:
- Shared include (nanorv32_parameters.v): NRV32 address/data MSBs, state encodings S_FETCH/S_STALL/S_DROP, default RESET_PC.
- Sub-module nanorv32_fetch_fifo: DEPTH-entry sync FIFO {pc, instr} with push, pop, clear, count, and head outputs. nanorv32_prefetch holds the FSM, fetch_pc, and the redirect register.

Test Plan:
- Reset release, memory ready=1 always, pf_ready=1 -> addr 0,4,8,… on consecutive cycles; pf_pc 0 appears 1 cycle after the first handshake; 1 instr/cycle.
- pf_ready=0, memory zero-wait -> exactly DEPTH=2 handshakes (addr 0,4), then valid=0; raising pf_ready resumes fetching at addr 8 with no loss or duplicate.
- Memory ready held low 3 cycles on addr 0x10 while branch_taken (target 0x103) pulses in cycle 1 -> addr stays 0x10 until ready, its data is not pushed, next request addr=0x100, next pf_pc=0x100.
- branch_taken (target 0x200) coincident with ready and pf_ready -> no push, no pop effect, FIFO empty next cycle, next request addr=0x200.
- Two branches (0x300, then 0x400) while in S_DROP -> only 0x400 is fetched; 0x300 never appears on addr.
- Fetch at 0xFFFF_FFFC with ready -> next addr 0x0000_0000; rst asserted mid-request -> valid=0 immediately, FIFO empty, restart at RESET_PC.
